fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch controller that sequences the combinational instruction memory for the RISC-V core. Holds the program counter and drives the instruction memory byte address. Captures each returned word with its PC into a 2-entry queue and presents it to decode over a valid/ready handshake. Also supports redirects (jumps/branches) and a halt/resume request from the debug/control logic.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.
- DEPTH, 2: queue entries. Legal values: 2 or 4.

- clock, input, 1: sole clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- imem_address, output, 32: byte address to instruction memory. Always equals the current PC.
- imem_instruction, input, 32: combinational read data for imem_address. Valid in the same cycle.
- redirect_valid, input, 1: one-cycle pulse requesting a PC change.
- redirect_target, input, 32: new PC. Bits [1:0] are ignored and forced to 0.
- out_valid, output, 1: queue head is valid.
- out_ready, input, 1: decode accepts the head.
- out_instruction, output, 32: instruction at the queue head.
- out_pc, output, 32: PC of the queue head.
- halt_req, input, 1: level request to stop fetching.
- resume, input, 1: pulse to leave HALTED.
- halted, output, 1: high in HALTED.
- fetch_count, output, 32: number of words pushed since reset. Wraps modulo 2^32.

## Operation
- State machine has three states: RUN, DRAIN, HALTED. Reset enters RUN.
- Fetch condition: state is RUN, redirect_valid is 0, and the queue is either not full or is being popped this cycle.
  - On fetch: push {pc, imem_instruction}, pc <= pc + 4, fetch_count += 1.
- PC arithmetic is 32-bit unsigned. 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- Pop: out_valid && out_ready removes the head. Push and pop may occur in the same cycle at any occupancy, including full.
- Redirect has highest priority, in every state:
  - Queue is flushed; any pop that cycle is discarded.
  - pc <= {redirect_target[31:2], 2'b00}.
  - No push that cycle.
  - State is not changed by the redirect itself.
- RUN → DRAIN when halt_req = 1. Fetching stops that same cycle; no push in the cycle halt_req is first seen.
- DRAIN → HALTED when the queue is empty, or will be empty after this cycle's pop or flush.
- DRAIN → RUN if halt_req drops before the queue empties.
- HALTED → RUN on resume = 1 with halt_req = 0. Resume while halt_req = 1 is ignored.
- A redirect in DRAIN or HALTED updates the PC and flushes the queue, then the state machine continues normally. This allows the debugger to set the PC while halted.
- The queue is a circular buffer with DEPTH entries. Read and write pointers wrap and an occupancy counter runs from 0 to DEPTH. Overflow and underflow are impossible by construction and are checked by assertions.

## Timing
- Reset values:
  - pc = RESET_PC, imem_address = RESET_PC.
  - Queue empty, out_valid = 0.
  - out_instruction = 0, out_pc = 0 (head registers cleared).
  - halted = 0, fetch_count = 0, state = RUN.
- First fetch happens in the first cycle with reset low. out_valid rises the following cycle.
- Fetch-to-out_valid latency is 1 cycle when the queue was empty.
- Sustained throughput is 1 instruction per cycle while out_ready stays high.
- Redirect at cycle N:
  - out_valid = 0 at N+1.
  - imem_address = target at N+1.
  - Target instruction is visible at N+2.
- halted asserts the cycle after the DRAIN → HALTED transition and deasserts the cycle after resume.
- Reset mid-operation (any state, queue full) restores all reset values on the next edge. In-flight entries are dropped.
- out_instruction and out_pc are stable while out_valid = 1 and out_ready = 0.

## Test plan
- Reset with RESET_PC = 0 and out_ready = 1. Memory returns word[0] = 0x00100310 and word[4] = 0x00000390. Required: out (pc 0, 0x00100310) at cycle 1, out (pc 4, 0x00000390) at cycle 2, then PCs 8, 12, … in consecutive cycles.
- Hold out_ready = 0 for 5 cycles. Required:
  - Queue holds pcs 0 and 4.
  - imem_address stays 8.
  - fetch_count = 2.
  - Head stays pc 0.
  - After release, pcs 0, 4, 8 delivered on consecutive cycles with no gap.
- Redirect to 0x0000_0006 while the queue is full. Required:
  - Next cycle out_valid = 0 and imem_address = 0x4.
  - Following cycle out_pc = 0x4.
  - Old entries are never delivered.
- Assert halt_req with 2 entries queued and out_ready = 1. Required: both entries delivered, then halted = 1, imem_address frozen, fetch_count unchanged. resume with halt_req = 0 brings out_valid back 1 cycle after fetching restarts.
- Redirect to 0xFFFF_FFFC, run 2 fetches. Required: out_pc sequence is 0xFFFF_FFFC, then 0x0000_0000.
- Assert reset mid-stream with the queue full in DRAIN. Required: next cycle out_valid = 0, halted = 0, pc = RESET_PC, fetch_count = 0.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch controller for the RISC-V core. Holds the program counter,
// addresses a combinational instruction memory, and captures each returned word
// together with its PC into a small circular queue. The queue head goes to
// decode over a valid/ready handshake. Redirects (jumps/branches) and a
// halt/resume request from debug/control logic are also handled here.
//
// Ports
//   clock             : sole clock, rising edge
//   reset             : synchronous active-high reset
//   imem_address      : byte address to instruction memory (== current PC)
//   imem_instruction  : combinational read data for imem_address
//   redirect_valid    : one-cycle pulse requesting a PC change
//   redirect_target   : new PC, bits [1:0] forced to zero
//   out_valid         : queue head valid
//   out_ready         : decode accepts the head
//   out_instruction   : instruction at queue head
//   out_pc            : PC of queue head
//   halt_req          : level request to stop fetching
//   resume            : pulse to leave HALTED
//   halted            : high while in HALTED
//   fetch_count       : words pushed since reset, wraps modulo 2^32
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    input  logic        halt_req,
    input  logic        resume,
    output logic        halted,
    output logic [31:0] fetch_count
);

    // DEPTH is 2 or 4, so the pointers are 1 or 2 bits and wrap naturally.
    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fetch_count_q, fetch_count_d;
    logic               halted_q, halted_d;
    logic [31:0]        q_instr_q [DEPTH];
    logic [31:0]        q_pc_q    [DEPTH];

    logic               full_s;
    logic               pop_s;
    logic               fetch_s;
    logic               unused_tgt_s;

    // Low target bits are architecturally ignored.
    assign unused_tgt_s = ^redirect_target[1:0];

    // Handshake qualifiers: a redirect discards any pop and suppresses the push.
    always_comb begin
        full_s  = (count_q == FULL_CNT);
        pop_s   = (count_q != {CNT_W{1'b0}}) && out_ready && !redirect_valid;
        fetch_s = (state_q == ST_RUN) && !redirect_valid && !halt_req &&
                  (!full_s || pop_s);
    end

    // Next-state logic for PC, queue bookkeeping, fetch counter and FSM.
    always_comb begin
        pc_d          = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fetch_count_d = fetch_count_q;
        state_d       = state_q;

        if (redirect_valid) begin
            pc_d     = {redirect_target[31:2], 2'b00};
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (fetch_s) begin
                pc_d          = pc_q + 32'd4;
                wr_ptr_d      = wr_ptr_q + PTR_ONE;
                fetch_count_d = fetch_count_q + 32'd1;
            end else begin
                pc_d = pc_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({fetch_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Halt withdrawn takes precedence; otherwise halt once nothing
                // remains after this cycle's pop or flush.
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (redirect_valid || (count_q == {CNT_W{1'b0}}) ||
                             ((count_q == CNT_ONE) && pop_s)) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_RUN;
        endcase

        halted_d = (state_d == ST_HALTED);
    end

    // State registers and queue storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            rd_ptr_q      <= {PTR_W{1'b0}};
            wr_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            fetch_count_q <= 32'd0;
            halted_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_q[i] <= 32'd0;
                q_pc_q[i]    <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_count_q <= fetch_count_d;
            halted_q      <= halted_d;
            if (fetch_s) begin
                q_instr_q[wr_ptr_q] <= imem_instruction;
                q_pc_q[wr_ptr_q]    <= pc_q;
            end
        end
    end

    assign imem_address    = pc_q;
    assign out_valid       = (count_q != {CNT_W{1'b0}});
    assign out_instruction = q_instr_q[rd_ptr_q];
    assign out_pc          = q_pc_q[rd_ptr_q];
    assign halted          = halted_q;
    assign fetch_count     = fetch_count_q;

    fetch_unit_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_checker (
        .clock   (clock),
        .reset   (reset),
        .count_i (count_q),
        .push_i  (fetch_s),
        .pop_i   (pop_s)
    );

endmodule

// -----------------------------------------------------------------------------
// fetch_unit_checker
// Queue occupancy invariants for fetch_unit: no push into a full queue without
// a simultaneous pop, no pop from an empty queue, occupancy never above DEPTH.
// Ports: clock, reset, count_i (occupancy), push_i, pop_i.
// -----------------------------------------------------------------------------
module fetch_unit_checker #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input logic             clock,
    input logic             reset,
    input logic [CNT_W-1:0] count_i,
    input logic             push_i,
    input logic             pop_i
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push_i && !pop_i && (count_i == FULL_CNT)));

    a_no_underflow: assert property (@(posedge clock) disable iff (reset)
        !(pop_i && (count_i == {CNT_W{1'b0}})));

    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        (count_i <= FULL_CNT));

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. The reference model is the instruction
// stream itself: delivered entries must be consecutive PCs starting at the reset
// PC or the latest redirect target, each paired with the memory word at that PC.
// Directed scenarios add cycle-exact checks for latency, stall, redirect, halt,
// PC wrap and mid-stream reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    logic [31:0] stream_pc;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock            (clock),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .halt_req         (halt_req),
        .resume           (resume),
        .halted           (halted),
        .fetch_count      (fetch_count)
    );

    // Memory image: two fixed words at 0 and 4, a scrambled address elsewhere.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0010_0310;
        else if (a == 32'h0000_0004) return 32'h0000_0390;
        else return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_instruction = mem_fn(imem_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Keep the expected stream topped up ahead of the monitor.
    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back({stream_pc, mem_fn(stream_pc)});
            stream_pc = stream_pc + 32'd4;
        end
    endtask

    task automatic step();
        refill();
        @(posedge clock);
        #1;
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        stream_pc = pc;
    endtask

    task automatic do_reset(input logic ready);
        reset          = 1'b1;
        out_ready      = ready;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        resume         = 1'b0;
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_imem_address", imem_address, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instruction, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        reset = 1'b0;
        restart_stream(32'd0);
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        restart_stream({tgt[31:2], 2'b00});
        step();
        redirect_valid = 1'b0;
    endtask

    // Scoreboard monitor: every accepted head must be the next expected entry.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got pc %h with no expected entry", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_pc", out_pc, mon_e.pc);
                chk("sb_instr", out_instruction, mon_e.instr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int r;
        reset           = 1'b1;
        redirect_target = 32'd0;
        redirect_valid  = 1'b0;
        out_ready       = 1'b1;
        halt_req        = 1'b0;
        resume          = 1'b0;
        stream_pc       = 32'd0;

        // Basic stream with out_ready high.
        do_reset(1'b1);
        chk("c0_imem_address", imem_address, 32'd0);
        step();
        chk("c1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("c1_out_pc", out_pc, 32'd0);
        chk("c1_out_instr", out_instruction, 32'h0010_0310);
        step();
        chk("c2_out_pc", out_pc, 32'd4);
        chk("c2_out_instr", out_instruction, 32'h0000_0390);
        step();
        chk("c3_out_pc", out_pc, 32'd8);

        // Stall with out_ready low.
        do_reset(1'b0);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_imem_address", imem_address, 32'd8);
            chk("stall_fetch_count", fetch_count, 32'd2);
            chk("stall_out_pc", out_pc, 32'd0);
            chk("stall_out_instr", out_instruction, 32'h0010_0310);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("release_pc4", out_pc, 32'd4);
        chk("release_valid4", {31'd0, out_valid}, 32'd1);
        step();
        chk("release_pc8", out_pc, 32'd8);
        chk("release_valid8", {31'd0, out_valid}, 32'd1);

        // Redirect with the queue full.
        out_ready = 1'b0;
        step();
        step();
        redirect_to(32'h0000_0006);
        chk("redir_out_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_imem_address", imem_address, 32'd4);
        step();
        chk("redir_n2_valid", {31'd0, out_valid}, 32'd1);
        chk("redir_n2_pc", out_pc, 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Halt with two entries queued, then resume.
        do_reset(1'b0);
        step();
        step();
        halt_req  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("drain_halted", {31'd0, halted}, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_out_valid", {31'd0, out_valid}, 32'd0);
            chk("halt_imem_address", imem_address, 32'd8);
            chk("halt_fetch_count", fetch_count, 32'd2);
            step();
        end
        halt_req = 1'b0;
        resume   = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_out_valid0", {31'd0, out_valid}, 32'd0);
        step();
        chk("resume_out_valid1", {31'd0, out_valid}, 32'd1);
        chk("resume_out_pc", out_pc, 32'd8);

        // PC wrap at the top of the address space.
        redirect_to(32'hFFFF_FFFC);
        chk("wrap_out_valid", {31'd0, out_valid}, 32'd0);
        chk("wrap_imem_address", imem_address, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc1", out_pc, 32'h0000_0000);

        // Reset while draining with a full queue.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        halt_req = 1'b1;
        step();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        step();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd0);
        chk("midrst_imem_address", imem_address, 32'd0);
        chk("midrst_fetch_count", fetch_count, 32'd0);
        reset    = 1'b0;
        halt_req = 1'b0;
        restart_stream(32'd0);

        // Randomized traffic, checked by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 4) begin
                redirect_valid  = 1'b1;
                redirect_target = $urandom;
                restart_stream({redirect_target[31:2], 2'b00});
            end else begin
                redirect_valid = 1'b0;
            end
            if (!halt_req && ($urandom_range(0, 99) < 3)) halt_req = 1'b1;
            else if (halt_req && ($urandom_range(0, 99) < 15)) halt_req = 1'b0;
            resume = ($urandom_range(0, 9) == 0);
            step();
        end

        // Release everything; fetching must resume within a bounded time.
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        resume         = 1'b1;
        out_ready      = 1'b1;
        step();
        resume = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        chk("final_progress", {31'd0, seen}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
